// File: rtl/core_lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
// The optional bus watchdog is enabled with the LSU_TIMEOUT_EN macro.
package core_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Bytes never fault; the unused 2'b10 encoding is handled like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic: byte enables, store data replication and
// load lane selection with sign/zero extension.
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;

  assign byte_lane_s = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane_s = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Decode the access size into enables, replicated store data and extended load data
  always_comb begin
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {(XLEN/8){wdata[7:0]}};
        if (is_unsigned) begin
          ld_data = {{(XLEN-8){1'b0}}, byte_lane_s};
        end else begin
          ld_data = {{(XLEN-8){byte_lane_s[7]}}, byte_lane_s};
        end
      end
      SIZE_HALF: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {(XLEN/16){wdata[15:0]}};
        if (is_unsigned) begin
          ld_data = {{(XLEN-16){1'b0}}, half_lane_s};
        end else begin
          ld_data = {{(XLEN-16){half_lane_s[15]}}, half_lane_s};
        end
      end
      default: begin
        be        = 4'hF;
        wdata_rep = wdata;
        ld_data   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/core_lsu_ctrl.sv
// Load/store unit controller: IDLE/REQ/WAIT/DONE handshake between the pipeline
// and a simple request/grant bus. Define LSU_TIMEOUT_EN to enable the bus watchdog.
module core_lsu_ctrl
  import core_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  input  logic            i_req_we,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_unsigned,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_ld_data,
  output logic            o_misalign,
  output logic            o_bus_err,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  lsu_state_e      state_r;
  lsu_state_e      next_state_s;
  logic            we_r;
  logic            uns_r;
  logic [1:0]      size_r;
  logic [1:0]      addr_lo_r;
  logic            accept_s;
  logic            misalign_s;
  logic            timeout_s;
  logic            load_ok_s;
  logic [1:0]      al_size_s;
  logic [1:0]      al_addr_lo_s;
  logic            al_uns_s;
  logic [3:0]      al_be_s;
  logic [XLEN-1:0] al_wdata_s;
  logic [XLEN-1:0] al_ld_s;
  logic            done_d_s;
  logic            mem_req_d_s;
  logic            misalign_d_s;
  logic [XLEN-1:0] ld_data_d_s;

  assign accept_s   = (state_r == ST_IDLE) && i_req_valid;
  assign misalign_s = is_misaligned(i_req_size, i_req_addr[1:0]);
  assign load_ok_s  = (state_r == ST_WAIT) && i_mem_rvalid;
  assign o_stall    = i_req_valid && (state_r != ST_DONE);

  // The aligner sees the live request while idle (to build bus fields) and the captured one afterwards
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_size_s    = i_req_size;
      al_addr_lo_s = i_req_addr[1:0];
      al_uns_s     = i_req_unsigned;
    end else begin
      al_size_s    = size_r;
      al_addr_lo_s = addr_lo_r;
      al_uns_s     = uns_r;
    end
  end

  core_lsu_align #(.XLEN(XLEN)) u_align (
    .size        (al_size_s),
    .addr_lo     (al_addr_lo_s),
    .is_unsigned (al_uns_s),
    .wdata       (i_req_wdata),
    .rdata       (i_mem_rdata),
    .be          (al_be_s),
    .wdata_rep   (al_wdata_s),
    .ld_data     (al_ld_s)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a real grant or read response wins over a simultaneous timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req_valid) begin
          next_state_s = misalign_s ? ST_DONE : ST_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_mem_gnt) begin
          next_state_s = we_r ? ST_DONE : ST_WAIT;
        end else if (timeout_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (i_mem_rvalid || timeout_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs, so they line up with the state
  always_comb begin
    done_d_s     = (next_state_s == ST_DONE);
    mem_req_d_s  = (next_state_s == ST_REQ);
    misalign_d_s = accept_s && misalign_s;
    ld_data_d_s  = o_ld_data;
    if (done_d_s) begin
      if (load_ok_s) begin
        ld_data_d_s = al_ld_s;
      end else begin
        ld_data_d_s = {XLEN{1'b0}};
      end
    end else begin
      ld_data_d_s = o_ld_data;
    end
  end

  // Output and request-capture registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_done      <= 1'b0;
      o_mem_req   <= 1'b0;
      o_misalign  <= 1'b0;
      o_ld_data   <= {XLEN{1'b0}};
      o_mem_we    <= 1'b0;
      o_mem_addr  <= {XLEN{1'b0}};
      o_mem_be    <= 4'h0;
      o_mem_wdata <= {XLEN{1'b0}};
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'b00;
      addr_lo_r   <= 2'b00;
    end else begin
      o_done     <= done_d_s;
      o_mem_req  <= mem_req_d_s;
      o_misalign <= misalign_d_s;
      o_ld_data  <= ld_data_d_s;
      if (accept_s) begin
        we_r        <= i_req_we;
        uns_r       <= i_req_unsigned;
        size_r      <= i_req_size;
        addr_lo_r   <= i_req_addr[1:0];
        o_mem_we    <= i_req_we;
        o_mem_addr  <= {i_req_addr[XLEN-1:2], 2'b00};
        o_mem_be    <= al_be_s;
        o_mem_wdata <= al_wdata_s;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;
  logic        bus_err_d_s;

  assign timeout_s   = ((state_r == ST_REQ) || (state_r == ST_WAIT)) &&
                       (tmo_cnt_r == 32'(TIMEOUT_CYCLES - 1));
  assign bus_err_d_s = timeout_s && (next_state_s == ST_DONE) &&
                       !((state_r == ST_REQ) && i_mem_gnt) && !load_ok_s;

  // Watchdog counter: cleared when a bus access starts, advances while it is outstanding
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt_r <= 32'd0;
    end else if (accept_s && !misalign_s) begin
      tmo_cnt_r <= 32'd0;
    end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end

  // Bus error flag, valid alongside o_done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bus_err <= 1'b0;
    end else begin
      o_bus_err <= bus_err_d_s;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign o_bus_err = 1'b0;
`endif

endmodule
